// File: rtl/decode_stage_reg_if.sv
// decode_stage_reg_if: fetch, forwarding and decode-result signals of the decode stage.
// master: drives D_stall/D_bubble, the f_* fetch fields, rvalA/rvalB and the
//         e_/M_/W_ destination IDs and values; receives the D_* and d_* outputs.
// slave:  the decode stage register itself (mirror of master).
interface decode_stage_reg_if;
   logic               D_stall, D_bubble;
   logic [1:0]         f_stat;
   logic [3:0]         f_icode, f_ifun, f_rA, f_rB;
   logic signed [63:0] f_valC, f_valP, rvalA, rvalB;
   logic [3:0]         e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
   logic signed [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
   logic [1:0]         D_stat;
   logic [3:0]         D_icode, D_ifun, D_rA, D_rB;
   logic signed [63:0] D_valC, D_valP;
   logic [3:0]         d_srcA, d_srcB, d_dstE, d_dstM;
   logic signed [63:0] d_valA, d_valB;
   modport master (
      output D_stall, D_bubble, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
             rvalA, rvalB, e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
             e_valE, M_valE, m_valM, W_valE, W_valM,
      input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
             d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB
   );
   modport slave (
      input  D_stall, D_bubble, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
             rvalA, rvalB, e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
             e_valE, M_valE, m_valM, W_valE, W_valM,
      output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
             d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB
   );
endinterface

// File: rtl/decode_stage_reg.sv
// decode_stage_reg: pipeline D register with stall/bubble control plus decode and operand forwarding.
// clk, reset: single clock, synchronous active-high reset (loads the nop state).
// bus (slave): fetch fields in, stall/bubble control, register-file read data and
//              downstream destinations/values in; registered D_* fields and
//              combinational d_* register IDs and forwarded operands out.
module decode_stage_reg (
   input logic               clk,
   input logic               reset,
   decode_stage_reg_if.slave bus
);
   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RRSP  = 4'h4;
   logic [1:0]         stat_q, stat_d;
   logic [3:0]         icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
   logic signed [63:0] valc_q, valc_d, valp_q, valp_d;
   logic [3:0]         src_a, src_b, dst_e, dst_m;
   logic signed [63:0] val_a, val_b;
   // Stall outranks bubble; reset outranks both inside the flop block.
   always_comb begin
      stat_d  = bus.D_stall ? stat_q  : bus.D_bubble ? 2'd0   : bus.f_stat;
      icode_d = bus.D_stall ? icode_q : bus.D_bubble ? 4'h1   : bus.f_icode;
      ifun_d  = bus.D_stall ? ifun_q  : bus.D_bubble ? 4'h0   : bus.f_ifun;
      ra_d    = bus.D_stall ? ra_q    : bus.D_bubble ? RNONE  : bus.f_rA;
      rb_d    = bus.D_stall ? rb_q    : bus.D_bubble ? RNONE  : bus.f_rB;
      valc_d  = bus.D_stall ? valc_q  : bus.D_bubble ? 64'sd0 : bus.f_valC;
      valp_d  = bus.D_stall ? valp_q  : bus.D_bubble ? 64'sd0 : bus.f_valP;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_q  <= 2'd0;
         icode_q <= 4'h1;
         ifun_q  <= 4'h0;
         ra_q    <= RNONE;
         rb_q    <= RNONE;
         valc_q  <= 64'sd0;
         valp_q  <= 64'sd0;
      end else begin
         stat_q  <= stat_d;
         icode_q <= icode_d;
         ifun_q  <= ifun_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         valc_q  <= valc_d;
         valp_q  <= valp_d;
      end
   end
   // Forwarding takes the youngest in-flight producer first; RNONE never matches,
   // so an idle stage reporting dst=F cannot hijack an unused operand.
   always_comb begin
      src_a = (icode_q inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra_q :
              (icode_q inside {4'h9, 4'hB}) ? RRSP : RNONE;
      src_b = (icode_q inside {4'h4, 4'h5, 4'h6}) ? rb_q :
              (icode_q inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RRSP : RNONE;
      dst_e = (icode_q inside {4'h2, 4'h3, 4'h6}) ? rb_q :
              (icode_q inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RRSP : RNONE;
      dst_m = (icode_q inside {4'h5, 4'hB}) ? ra_q : RNONE;
      val_a = (icode_q inside {4'h7, 4'h8})              ? valp_q     :
              (src_a != RNONE && src_a == bus.e_dstE)    ? bus.e_valE :
              (src_a != RNONE && src_a == bus.M_dstM)    ? bus.m_valM :
              (src_a != RNONE && src_a == bus.M_dstE)    ? bus.M_valE :
              (src_a != RNONE && src_a == bus.W_dstM)    ? bus.W_valM :
              (src_a != RNONE && src_a == bus.W_dstE)    ? bus.W_valE : bus.rvalA;
      val_b = (src_b != RNONE && src_b == bus.e_dstE)    ? bus.e_valE :
              (src_b != RNONE && src_b == bus.M_dstM)    ? bus.m_valM :
              (src_b != RNONE && src_b == bus.M_dstE)    ? bus.M_valE :
              (src_b != RNONE && src_b == bus.W_dstM)    ? bus.W_valM :
              (src_b != RNONE && src_b == bus.W_dstE)    ? bus.W_valE : bus.rvalB;
   end
   assign bus.D_stat  = stat_q;
   assign bus.D_icode = icode_q;
   assign bus.D_ifun  = ifun_q;
   assign bus.D_rA    = ra_q;
   assign bus.D_rB    = rb_q;
   assign bus.D_valC  = valc_q;
   assign bus.D_valP  = valp_q;
   assign bus.d_srcA  = src_a;
   assign bus.d_srcB  = src_b;
   assign bus.d_dstE  = dst_e;
   assign bus.d_dstM  = dst_m;
   assign bus.d_valA  = val_a;
   assign bus.d_valB  = val_b;
endmodule

// File: tb/tb_decode_stage_reg.sv
// tb_decode_stage_reg: directed and random checks of decode_stage_reg against a table-driven model.
module tb_decode_stage_reg;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   decode_stage_reg_if bus ();
   decode_stage_reg dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   // Per-icode membership masks, bit i set means icode i belongs to the set.
   logic [15:0] sa_ra = 16'h0454, sa_sp = 16'h0A00;
   logic [15:0] sb_rb = 16'h0070, sb_sp = 16'h0F00;
   logic [15:0] de_rb = 16'h004C, de_sp = 16'h0F00;
   logic [15:0] dm_ra = 16'h0820, va_vp = 16'h0180;
   logic [1:0]         m_stat;
   logic [3:0]         m_icode, m_ifun, m_ra, m_rb;
   logic signed [63:0] m_valc, m_valp;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic model_nop();
      m_stat = 0; m_icode = 1; m_ifun = 0; m_ra = 4'hF; m_rb = 4'hF; m_valc = 0; m_valp = 0;
   endtask
   task automatic model_clock();
      if (reset) model_nop();
      else if (bus.D_stall) ;
      else if (bus.D_bubble) model_nop();
      else begin
         m_stat = bus.f_stat; m_icode = bus.f_icode; m_ifun = bus.f_ifun;
         m_ra = bus.f_rA; m_rb = bus.f_rB; m_valc = bus.f_valC; m_valp = bus.f_valP;
      end
   endtask
   function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] rval);
      logic [3:0]  dst[5];
      logic [63:0] val[5];
      dst = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
      val = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
      if (src == 4'hF) return rval;
      for (int i = 0; i < 5; i++) if (dst[i] == src) return val[i];
      return rval;
   endfunction
   task automatic check_all(input string tag);
      logic [3:0] sa, sb, de, dm;
      sa = sa_ra[m_icode] ? m_ra : sa_sp[m_icode] ? 4'h4 : 4'hF;
      sb = sb_rb[m_icode] ? m_rb : sb_sp[m_icode] ? 4'h4 : 4'hF;
      de = de_rb[m_icode] ? m_rb : de_sp[m_icode] ? 4'h4 : 4'hF;
      dm = dm_ra[m_icode] ? m_ra : 4'hF;
      chk({tag, ".D_stat"},  64'(bus.D_stat),  64'(m_stat));
      chk({tag, ".D_icode"}, 64'(bus.D_icode), 64'(m_icode));
      chk({tag, ".D_ifun"},  64'(bus.D_ifun),  64'(m_ifun));
      chk({tag, ".D_rA"},    64'(bus.D_rA),    64'(m_ra));
      chk({tag, ".D_rB"},    64'(bus.D_rB),    64'(m_rb));
      chk({tag, ".D_valC"},  bus.D_valC, m_valc);
      chk({tag, ".D_valP"},  bus.D_valP, m_valp);
      chk({tag, ".d_srcA"},  64'(bus.d_srcA), 64'(sa));
      chk({tag, ".d_srcB"},  64'(bus.d_srcB), 64'(sb));
      chk({tag, ".d_dstE"},  64'(bus.d_dstE), 64'(de));
      chk({tag, ".d_dstM"},  64'(bus.d_dstM), 64'(dm));
      chk({tag, ".d_valA"},  bus.d_valA, va_vp[m_icode] ? m_valp : fwd(sa, bus.rvalA));
      chk({tag, ".d_valB"},  bus.d_valB, fwd(sb, bus.rvalB));
   endtask
   task automatic step(input string tag);
      @(posedge clk);
      model_clock();
      #1;
      check_all(tag);
   endtask
   task automatic fetch(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] vc, input logic [63:0] vp);
      bus.f_stat = 0; bus.f_icode = ic; bus.f_ifun = 0; bus.f_rA = ra; bus.f_rB = rb;
      bus.f_valC = vc; bus.f_valP = vp;
   endtask
   task automatic quiet_fwd();
      bus.e_dstE = 4'hF; bus.M_dstE = 4'hF; bus.M_dstM = 4'hF; bus.W_dstE = 4'hF; bus.W_dstM = 4'hF;
      bus.e_valE = 64'hE0; bus.M_valE = 64'hE1; bus.m_valM = 64'hE2;
      bus.W_valE = 64'hE3; bus.W_valM = 64'hE4; bus.rvalA = 64'hA0; bus.rvalB = 64'hB0;
   endtask
   function automatic logic [3:0] rnd_reg();
      return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
   endfunction
   initial begin
      reset = 1; bus.D_stall = 0; bus.D_bubble = 0;
      fetch(4'h6, 4'h2, 4'h3, 0, 0);
      quiet_fwd();
      step("reset");
      chk("reset_srcA", 64'(bus.d_srcA), 64'hF);
      reset = 0;
      step("opq");
      chk("opq_icode", 64'(bus.D_icode), 64'h6);
      chk("opq_srcA",  64'(bus.d_srcA), 64'h2);
      chk("opq_srcB",  64'(bus.d_srcB), 64'h3);
      chk("opq_dstE",  64'(bus.d_dstE), 64'h3);
      chk("opq_dstM",  64'(bus.d_dstM), 64'hF);
      fetch(4'h3, 4'hF, 4'h1, 64'h1234, 64'h8);
      step("irmovq");
      bus.D_stall = 1; bus.D_bubble = 1;
      fetch(4'h5, 4'h1, 4'h2, 64'h99, 64'h98);
      step("stall_bubble");
      chk("stall_icode", 64'(bus.D_icode), 64'h3);
      bus.D_stall = 0;
      step("bubble");
      chk("bubble_icode", 64'(bus.D_icode), 64'h1);
      chk("bubble_rA",    64'(bus.D_rA), 64'hF);
      bus.D_bubble = 0;
      fetch(4'h6, 4'h2, 4'h7, 0, 64'h10);
      step("opq_fwd");
      bus.e_dstE = 4'h2; bus.e_valE = 64'h11; bus.M_dstE = 4'h2; bus.M_valE = 64'h22;
      #1 chk("fwd_e", bus.d_valA, 64'h11);
      check_all("fwd_e");
      bus.e_dstE = 4'hF;
      #1 chk("fwd_M", bus.d_valA, 64'h22);
      check_all("fwd_M");
      quiet_fwd();
      fetch(4'h8, 4'hF, 4'hF, 64'h200, 64'h40);
      step("call");
      bus.e_dstE = 4'h4; bus.e_valE = 64'h55;
      #1;
      chk("call_valA", bus.d_valA, 64'h40);
      chk("call_srcB", 64'(bus.d_srcB), 64'h4);
      chk("call_valB", bus.d_valB, 64'h55);
      quiet_fwd();
      fetch(4'hB, 4'h5, 4'hF, 0, 64'h2);
      step("popq");
      bus.W_dstM = 4'h4; bus.W_valM = 64'h100;
      #1;
      chk("popq_srcA", 64'(bus.d_srcA), 64'h4);
      chk("popq_valA", bus.d_valA, 64'h100);
      chk("popq_dstM", 64'(bus.d_dstM), 64'h5);
      chk("popq_dstE", 64'(bus.d_dstE), 64'h4);
      quiet_fwd();
      fetch(4'h3, 4'hF, 4'h1, 64'hAB, 64'hA);
      step("irmovq2");
      bus.e_dstE = 4'hF; bus.e_valE = 64'hDEAD; bus.rvalA = 64'h7;
      #1 chk("none_valA", bus.d_valA, 64'h7);
      bus.D_stall = 1; reset = 1;
      step("reset_over_stall");
      chk("rst_dstE", 64'(bus.d_dstE), 64'hF);
      bus.D_stall = 0; reset = 0;
      for (int n = 0; n < 300; n++) begin
         reset = ($urandom_range(0, 29) == 0);
         bus.D_stall = ($urandom_range(0, 5) == 0);
         bus.D_bubble = ($urandom_range(0, 5) == 0);
         bus.f_stat = 2'($urandom); bus.f_icode = 4'($urandom_range(0, 11)); bus.f_ifun = 4'($urandom);
         bus.f_rA = rnd_reg(); bus.f_rB = rnd_reg();
         bus.f_valC = {$urandom, $urandom}; bus.f_valP = {$urandom, $urandom};
         bus.e_dstE = rnd_reg(); bus.M_dstE = rnd_reg(); bus.M_dstM = rnd_reg();
         bus.W_dstE = rnd_reg(); bus.W_dstM = rnd_reg();
         bus.e_valE = {$urandom, $urandom}; bus.M_valE = {$urandom, $urandom};
         bus.m_valM = {$urandom, $urandom}; bus.W_valE = {$urandom, $urandom};
         bus.W_valM = {$urandom, $urandom};
         bus.rvalA = {$urandom, $urandom}; bus.rvalB = {$urandom, $urandom};
         step("rand");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/decode_stage_reg.md
DECODE_STAGE_REG -- requirements
Module: decode_stage_reg

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- D_stall  in  1  hold D register contents.
- D_bubble  in  1  load nop into D register.
- f_stat  in  2  fetch status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- f_icode  in  4  fetched icode.
- f_ifun  in  4  fetched ifun.
- f_rA  in  4  fetched rA.
- f_rB  in  4  fetched rB.
- f_valC  in  64 signed  fetched constant.
- f_valP  in  64 signed  fetched next PC.
- rvalA  in  64 signed  register-file read data for d_srcA.
- rvalB  in  64 signed  register-file read data for d_srcB.
- e_dstE  in  4  execute-stage dstE.
- e_valE  in  64 signed  execute-stage ALU result.
- M_dstE  in  4  memory-stage dstE.
- M_valE  in  64 signed  memory-stage valE.
- M_dstM  in  4  memory-stage dstM.
- m_valM  in  64 signed  memory read data.
- W_dstE  in  4  writeback-stage dstE.
- W_valE  in  64 signed  writeback-stage valE.
- W_dstM  in  4  writeback-stage dstM.
- W_valM  in  64 signed  writeback-stage valM.
- D_stat, D_icode, D_ifun, D_rA, D_rB  out  2/4/4/4/4  registered D fields.
- D_valC, D_valP  out  64 signed  registered D fields.
- d_srcA, d_srcB, d_dstE, d_dstM  out  4  decoded register IDs to the register file and execute register.
- d_valA, d_valB  out  64 signed  forwarded operands to the execute register.

Function
REQ-002 Register IDs: 4 = RSP, F = none; icodes: 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
REQ-003 Each posedge, priority order: reset, then D_stall, then D_bubble, then normal load.
REQ-004 Normal load SHALL capture f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP into the matching D_* registers; latency one cycle.
REQ-005 D_stall=1 SHALL hold every D_* register unchanged; D_bubble is ignored while D_stall=1.
REQ-006 D_bubble=1 with D_stall=0 SHALL load the nop state: D_stat=0, D_icode=1, D_ifun=0, D_rA=F, D_rB=F, D_valC=0, D_valP=0.
REQ-007 d_srcA SHALL be D_rA for icode 2, 4, 6 or A; 4 for icode 9 or B; otherwise F.
REQ-008 d_srcB SHALL be D_rB for icode 4, 5 or 6; 4 for icode 8, 9, A or B; otherwise F.
REQ-009 d_dstE SHALL be D_rB for icode 2, 3 or 6; 4 for icode 8, 9, A or B; otherwise F.
REQ-010 d_dstM SHALL be D_rA for icode 5 or B; otherwise F.
REQ-011 d_valA SHALL use the first matching source in this order:
- D_valP when icode is 7 or 8.
- e_valE when d_srcA==e_dstE.
- m_valM when d_srcA==M_dstM.
- M_valE when d_srcA==M_dstE.
- W_valM when d_srcA==W_dstM.
- W_valE when d_srcA==W_dstE.
- otherwise rvalA.
REQ-012 d_valB SHALL use the same order as REQ-011 with d_srcB and rvalB, and without the D_valP term.
REQ-013 No forwarding match SHALL occur when the source ID is F, even if a stage dst is F.
REQ-014 d_* outputs SHALL be combinational from the D registers and the forwarding inputs; no extra cycle.
REQ-015 Values SHALL pass through as full 64 bits with no truncation or sign change.

Reset
REQ-016 reset=1 at a posedge SHALL load the nop state of REQ-006; reset overrides D_stall and D_bubble.
REQ-017 Reset asserted mid-stream SHALL discard the held instruction; after reset, d_srcA=d_srcB=d_dstE=d_dstM=F.

Verification
REQ-018 The bench SHALL cover:
- Reset, then f_icode=6, f_rA=2, f_rB=3 -> next cycle D_icode=6, d_srcA=2, d_srcB=3, d_dstE=3, d_dstM=F.
- D_stall=1 and D_bubble=1 together while holding icode 3 -> D_icode stays 3; then D_bubble alone -> D_icode=1, D_rA=F.
- OPq rA=2 with e_dstE=2, e_valE=0x11, M_dstE=2, M_valE=0x22 -> d_valA=0x11; set e_dstE=F -> d_valA=0x22.
- call with D_valP=0x40, e_dstE=4 -> d_valA=0x40, d_srcB=4, d_valB=e_valE.
- popq rA=5 with W_dstM=4, W_valM=0x100 and nothing else matching -> d_srcA=4, d_valA=0x100, d_dstM=5, d_dstE=4.
- irmovq (srcA=F) with e_dstE=F, e_valE=0xDEAD, rvalA=0x7 -> d_valA=0x7.
